// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared constants and FSM encoding for the FTDI sync FIFO bridge
package ftdi_pkg;

  localparam int FT_W = 8;
  localparam logic [FT_W-1:0] CMD_STOP = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_OE    = 3'd1,
    ST_RX_READ  = 3'd2,
    ST_TURN     = 3'd3,
    ST_TX_WRITE = 3'd4
  } ftdi_state_t;

endpackage

// File: rtl/ftdi_rx_skid.sv
// rtl/ftdi_rx_skid.sv - 2-entry valid/ready skid buffer for bytes read from the FTDI
module ftdi_rx_skid
  import ftdi_pkg::*;
(
  input  logic            clk,
  input  logic            n_rst,
  input  logic            push,
  input  logic [FT_W-1:0] push_data,
  output logic [FT_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [1:0]      count,
  output logic [1:0]      count_nxt
);

  logic [FT_W-1:0] head_q;
  logic [FT_W-1:0] tail_q;
  logic            pop;
  logic            push_ok;
  logic [1:0]      after_pop;

  assign rx_valid  = (count != 2'd0);
  assign rx_data   = head_q;
  assign pop       = rx_valid && rx_ready;
  assign push_ok   = push && ((count != 2'd2) || pop);
  assign after_pop = pop ? (count - 2'd1) : count;
  assign count_nxt = push_ok ? (after_pop + 2'd1) : after_pop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      count <= count_nxt;
      if (pop && (count == 2'd2)) head_q <= tail_q;
      // New byte lands in the first slot left free once this cycle's pop is applied.
      if (push_ok) begin
        if (after_pop == 2'd0) head_q <= push_data;
        else                   tail_q <= push_data;
      end
    end
  end

endmodule

// File: rtl/ftdi_sync_fifo_bridge.sv
// rtl/ftdi_sync_fifo_bridge.sv - FT245 synchronous FIFO bridge with burst-limited RX/TX arbitration
module ftdi_sync_fifo_bridge
  import ftdi_pkg::*;
#(
  parameter int MAX_BURST   = 64,
  parameter int RX_PRIORITY = 1,
  parameter int CMD_MODE    = 1,
  parameter int TURN_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [FT_W-1:0]  ft_data_i,
  output logic [FT_W-1:0]  ft_data_o,
  output logic             ft_data_oe,
  input  logic             rxf_n,
  input  logic             txe_n,
  output logic             oe_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic [FT_W-1:0]  rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [FT_W-1:0]  tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             run,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count
);

  localparam int                 BURST_W    = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [15:0]        TURN_LOAD  = (TURN_CYCLES > 0) ? 16'(TURN_CYCLES - 1) : 16'd0;

  ftdi_state_t        state;
  logic [BURST_W-1:0] rx_burst;
  logic [BURST_W-1:0] tx_loaded;
  logic [15:0]        turn_cnt;
  logic               last_rx;
  logic               tx_pending;
  logic [1:0]         skid_cnt;
  logic [1:0]         skid_cnt_nxt;

  logic rx_commit;
  logic rx_stop;
  logic rx_req;
  logic tx_req;
  logic pick_rx;
  logic tx_accept;
  logic tx_load;
  logic tx_pend_nxt;

  ftdi_rx_skid u_skid (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (rx_commit),
    .push_data (ft_data_i),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .count     (skid_cnt),
    .count_nxt (skid_cnt_nxt)
  );

  assign rx_commit = (state == ST_RX_READ) && !rd_n && !rxf_n;
  // rd_n is registered, so one more byte can land after the decision; stop while a slot is still free.
  assign rx_stop   = rxf_n || (skid_cnt_nxt == 2'd2) || (rx_commit && (rx_burst == BURST_LAST));

  assign rx_req  = !rxf_n && (skid_cnt == 2'd0);
  assign tx_req  = !txe_n && tx_valid;
  assign pick_rx = rx_req && (!tx_req || (RX_PRIORITY != 0) || !last_rx);

  assign tx_accept   = (state == ST_TX_WRITE) && tx_pending && !txe_n;
  assign tx_ready    = (state == ST_TX_WRITE) && (!tx_pending || tx_accept) && (tx_loaded != BURST_MAX);
  assign tx_load     = tx_ready && tx_valid;
  assign tx_pend_nxt = tx_load || (tx_pending && !tx_accept);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      oe_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      ft_data_oe <= 1'b0;
      ft_data_o  <= '0;
      run        <= 1'b0;
      rx_count   <= '0;
      tx_count   <= '0;
      rx_burst   <= '0;
      tx_loaded  <= '0;
      turn_cnt   <= '0;
      last_rx    <= 1'b0;
      tx_pending <= 1'b0;
    end else begin
      if (rx_commit) begin
        rx_count <= rx_count + CNT_ONE;
        rx_burst <= rx_burst + BURST_ONE;
        if (CMD_MODE != 0) run <= (ft_data_i != CMD_STOP);
      end
      if (tx_accept) tx_count <= tx_count + CNT_ONE;
      if (tx_load) begin
        ft_data_o <= tx_data;
        tx_loaded <= tx_loaded + BURST_ONE;
      end
      if (state == ST_TX_WRITE) begin
        tx_pending <= tx_pend_nxt;
        wr_n       <= !tx_pend_nxt;
      end

      case (state)
        ST_IDLE: begin
          if (pick_rx) begin
            state    <= ST_RX_OE;
            oe_n     <= 1'b0;
            rx_burst <= '0;
            last_rx  <= 1'b1;
          end else if (tx_req) begin
            state      <= ST_TX_WRITE;
            ft_data_oe <= 1'b1;
            tx_loaded  <= '0;
            last_rx    <= 1'b0;
          end
        end
        ST_RX_OE: begin
          state <= ST_RX_READ;
          rd_n  <= 1'b0;
        end
        ST_RX_READ: begin
          if (rx_stop) begin
            rd_n     <= 1'b1;
            oe_n     <= 1'b1;
            turn_cnt <= TURN_LOAD;
            state    <= (TURN_CYCLES > 0) ? ST_TURN : ST_IDLE;
          end
        end
        ST_TURN: begin
          if (turn_cnt == 16'd0) state <= ST_IDLE;
          else                   turn_cnt <= turn_cnt - 16'd1;
        end
        ST_TX_WRITE: begin
          if (!tx_pend_nxt && (!tx_valid || (tx_loaded == BURST_MAX))) begin
            state      <= ST_TURN;
            ft_data_oe <= 1'b0;
            turn_cnt   <= 16'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi_sync_fifo_bridge.sv
// tb/tb_ftdi_sync_fifo_bridge.sv - directed self-checking bench with FTDI chip and stream models
module tb_ftdi_sync_fifo_bridge;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  ft_data_i = 8'h00;
  logic [7:0]  ft_data_o;
  logic        ft_data_oe;
  logic        rxf_n = 1'b1;
  logic        txe_n = 1'b1;
  logic        oe_n, rd_n, wr_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        run;
  logic [15:0] rx_count, tx_count;

  ftdi_sync_fifo_bridge #(
    .MAX_BURST   (4),
    .RX_PRIORITY (0),
    .CMD_MODE    (1),
    .TURN_CYCLES (1),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .ft_data_i  (ft_data_i),
    .ft_data_o  (ft_data_o),
    .ft_data_oe (ft_data_oe),
    .rxf_n      (rxf_n),
    .txe_n      (txe_n),
    .oe_n       (oe_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .run        (run),
    .rx_count   (rx_count),
    .tx_count   (tx_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_bytes[$];
  logic [7:0] tx_src[$];
  logic [7:0] rx_got[$];
  logic [7:0] tx_seen[$];
  logic       run_hist[$];
  logic       ev_log[$];
  int  rx_idx = 0, tx_idx = 0;
  logic txe_hold = 1'b1;
  int  both_low = 0, oe_clash = 0, wr_low_cyc = 0, oe_high_cyc = 0;
  int  cyc = 0, oe_fall_cyc = -1, rd_fall_cyc = -1;
  logic prev_oe = 1'b1, prev_rd = 1'b1, last_run = 1'b0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FTDI chip and stream models: drive at negedge, then log what the next posedge will do.
  always @(negedge clk) begin
    rxf_n     = (rx_idx >= rx_bytes.size());
    ft_data_i = rxf_n ? 8'h00 : rx_bytes[rx_idx];
    tx_valid  = (tx_idx < tx_src.size());
    tx_data   = tx_valid ? tx_src[tx_idx] : 8'h00;
    txe_n     = txe_hold;
    #1;
    cyc++;
    if (n_rst) begin
      if (!rd_n && !rxf_n) begin rx_idx++; ev_log.push_back(1'b0); end
      if (!wr_n && !txe_n) begin tx_seen.push_back(ft_data_o); ev_log.push_back(1'b1); end
      if (tx_ready && tx_valid) tx_idx++;
      if (rx_valid && rx_ready) rx_got.push_back(rx_data);
      if (!rd_n && !wr_n) both_low++;
      if (ft_data_oe && !oe_n) oe_clash++;
      if (!wr_n) wr_low_cyc++;
      if (ft_data_oe) oe_high_cyc++;
      if (prev_oe && !oe_n && oe_fall_cyc < 0) oe_fall_cyc = cyc;
      if (prev_rd && !rd_n && rd_fall_cyc < 0) rd_fall_cyc = cyc;
      if (run != last_run) run_hist.push_back(run);
    end
    prev_oe  = oe_n;
    prev_rd  = rd_n;
    last_run = run;
  end

  initial begin
    logic [23:0] ev_word;
    bit found;

    tick(3);
    expect_eq("rst_strobes", {oe_n, rd_n, wr_n}, 3'b111);
    expect_eq("rst_oe", ft_data_oe, 1'b0);
    expect_eq("rst_data_o", ft_data_o, 8'h00);
    expect_eq("rst_valid_ready_run", {rx_valid, tx_ready, run}, 3'b000);
    expect_eq("rst_counts", {rx_count, tx_count}, 32'h0);
    n_rst = 1'b1;
    tick(2);

    // 1: three RX bytes with run decoding
    rx_ready = 1'b1;
    txe_hold = 1'b0;
    rx_bytes = '{8'hA5, 8'h00, 8'h3C};
    for (int i = 0; i < 40 && rx_got.size() < 3; i++) tick(1);
    tick(6);
    expect_eq("t1_rx_n", rx_got.size(), 3);
    for (int i = 0; i < 3; i++) expect_eq($sformatf("t1_rx%0d", i), rx_got[i], rx_bytes[i]);
    expect_eq("t1_oe_to_rd", rd_fall_cyc - oe_fall_cyc, 1);
    expect_eq("t1_run_n", run_hist.size(), 3);
    if (run_hist.size() == 3) expect_eq("t1_run_seq", {run_hist[0], run_hist[1], run_hist[2]}, 3'b101);
    expect_eq("t1_rx_count", rx_count, 3);
    expect_eq("t1_no_oe", oe_high_cyc, 0);

    // 2: five TX bytes, split 4+1 by the burst limit
    oe_high_cyc = 0; wr_low_cyc = 0;
    tx_src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 60 && tx_seen.size() < 5; i++) tick(1);
    tick(6);
    expect_eq("t2_tx_n", tx_seen.size(), 5);
    for (int i = 0; i < 5; i++) expect_eq($sformatf("t2_tx%0d", i), tx_seen[i], tx_src[i]);
    expect_eq("t2_wr_low", wr_low_cyc, 5);
    expect_eq("t2_oe_high", oe_high_cyc, 7);
    expect_eq("t2_tx_count", tx_count, 5);
    expect_eq("t2_oe_idle", ft_data_oe, 1'b0);

    // 3: txe_n stall on byte 13
    tx_seen.delete(); tx_src.delete(); tx_idx = 0;
    tx_src = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (!wr_n && ft_data_o == 8'h13) found = 1'b1;
    end
    expect_eq("t3_found13", found, 1'b1);
    txe_hold = 1'b1;
    tick(1);
    expect_eq("t3_held", {wr_n, ft_data_o}, {1'b0, 8'h13});
    tick(1);
    txe_hold = 1'b0;
    for (int i = 0; i < 60 && tx_seen.size() < 5; i++) tick(1);
    tick(6);
    expect_eq("t3_tx_n", tx_seen.size(), 5);
    for (int i = 0; i < 5; i++) expect_eq($sformatf("t3_tx%0d", i), tx_seen[i], tx_src[i]);
    expect_eq("t3_tx_count", tx_count, 10);

    // 4: RX backpressure, skid fills then drains
    rx_ready = 1'b0;
    rx_got.delete(); rx_bytes.delete(); rx_idx = 0;
    for (int i = 0; i < 10; i++) rx_bytes.push_back(8'h20 + 8'(i));
    tick(20);
    expect_eq("t4_taken", rx_idx, 2);
    expect_eq("t4_rd_high", rd_n, 1'b1);
    expect_eq("t4_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    for (int i = 0; i < 200 && rx_got.size() < 10; i++) tick(1);
    tick(6);
    expect_eq("t4_rx_n", rx_got.size(), 10);
    for (int i = 0; i < 10; i++) expect_eq($sformatf("t4_rx%0d", i), rx_got[i], 8'h20 + 8'(i));
    expect_eq("t4_rx_count", rx_count, 13);

    // 5: contention with round-robin, last served was RX
    rx_got.delete(); rx_bytes.delete(); rx_idx = 0;
    tx_seen.delete(); tx_src.delete(); tx_idx = 0;
    ev_log.delete();
    for (int i = 0; i < 16; i++) rx_bytes.push_back(8'h40 + 8'(i));
    for (int i = 0; i < 8; i++) tx_src.push_back(8'h80 + 8'(i));
    for (int i = 0; i < 400 && (rx_got.size() < 16 || tx_seen.size() < 8); i++) tick(1);
    tick(6);
    expect_eq("t5_ev_n", ev_log.size(), 24);
    ev_word = '0;
    for (int i = 0; i < ev_log.size() && i < 24; i++) ev_word = {ev_word[22:0], ev_log[i]};
    expect_eq("t5_order", ev_word, 24'hF0F000);
    for (int i = 0; i < 16 && i < rx_got.size(); i++) expect_eq($sformatf("t5_rx%0d", i), rx_got[i], 8'h40 + 8'(i));
    for (int i = 0; i < 8 && i < tx_seen.size(); i++) expect_eq($sformatf("t5_tx%0d", i), tx_seen[i], 8'h80 + 8'(i));
    expect_eq("t5_counts", {rx_count, tx_count}, {16'd29, 16'd18});

    // 6: reset in the middle of an RX burst
    rx_got.delete(); rx_bytes.delete(); rx_idx = 0;
    for (int i = 0; i < 8; i++) rx_bytes.push_back(8'h60 + 8'(i));
    for (int i = 0; i < 40 && rx_idx < 2; i++) tick(1);
    expect_eq("t6_run_before", run, 1'b1);
    n_rst = 1'b0;
    #1;
    expect_eq("t6_strobes", {oe_n, rd_n, wr_n, ft_data_oe}, 4'b1110);
    expect_eq("t6_run", run, 1'b0);
    expect_eq("t6_counts", {rx_count, tx_count}, 32'h0);
    expect_eq("t6_valid", rx_valid, 1'b0);
    rx_bytes.delete(); rx_idx = 0; rx_got.delete();
    tick(2);
    rx_bytes = '{8'h70, 8'h71, 8'h72};
    n_rst = 1'b1;
    for (int i = 0; i < 40 && rx_got.size() < 3; i++) tick(1);
    tick(6);
    expect_eq("t6_rx_n", rx_got.size(), 3);
    for (int i = 0; i < 3 && i < rx_got.size(); i++) expect_eq($sformatf("t6_rx%0d", i), rx_got[i], 8'h70 + 8'(i));
    expect_eq("t6_rx_count", rx_count, 3);
    expect_eq("t6_run_after", run, 1'b1);

    expect_eq("both_strobes_low", both_low, 0);
    expect_eq("oe_while_ftdi_drives", oe_clash, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
